// File: rtl/sm4_pkg.sv
// Shared SM4 constants, FSM state type and linear-transform helpers used by the iterative core
// and by the key-schedule unit.
package sm4_pkg;

  localparam int unsigned NUM_ROUNDS = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BLOCK_W    = 128;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Entry 0 sits in the most significant byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  localparam logic [0:3][31:0] FK = {32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  localparam logic [0:31][31:0] CK = {
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] L_enc(input logic [31:0] b);
    return b ^ rotl32(b, 2) ^ rotl32(b, 10) ^ rotl32(b, 18) ^ rotl32(b, 24);
  endfunction

endpackage

// File: rtl/sm4_round.sv
// One combinational SM4 round: X4 = X0 ^ L(tau(X1 ^ X2 ^ X3 ^ rk)).
module sm4_round
  import sm4_pkg::*;
(
  input  logic [31:0] x0,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [31:0] x3,
  input  logic [31:0] rk,
  output logic [31:0] x4
);

  logic [31:0] a;
  logic [31:0] b;

  always_comb begin
    a  = x1 ^ x2 ^ x3 ^ rk;
    b  = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    x4 = x0 ^ L_enc(b);
  end

endmodule

// File: rtl/sm4_iter_core.sv
// Iterative SM4 engine: UNROLL rounds per clock, valid/ready streaming, tracked round-key file
// and optional CBC chaining.
module sm4_iter_core
  import sm4_pkg::*;
#(
  parameter int unsigned UNROLL = 4,
  parameter bit          CBC_EN = 1'b0
) (
  input  logic         top_clk,
  input  logic         top_rst,
  input  logic         top_en,
  input  logic [4:0]   top_keyaddr,
  input  logic [31:0]  top_rk,
  output logic         rk_ready,
  input  logic         mode,
  input  logic         cbc,
  input  logic         iv_load,
  input  logic [127:0] iv_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16 &&
      UNROLL != 32) begin : g_bad_unroll
    $error("sm4_iter_core: UNROLL must be one of 1, 2, 4, 8, 16, 32");
  end

  state_e                  state_q, state_d;
  logic [WORD_W-1:0]       x_q [4];
  logic [WORD_W-1:0]       w [UNROLL+4];
  logic [WORD_W-1:0]       rk_mem [NUM_ROUNDS];
  logic [NUM_ROUNDS-1:0]   rk_bits_q;
  logic [5:0]              cnt_q;
  logic                    mode_q, cbc_q;
  logic [BLOCK_W-1:0]      iv_q, ct_q, out_data_q, blk_in, blk_res;
  logic                    accept, last, key_wr;

  assign rk_ready  = &rk_bits_q;
  assign in_ready  = (state_q == StIdle) && rk_ready && !iv_load;
  assign accept    = in_valid && in_ready;
  assign last      = (cnt_q == 6'(NUM_ROUNDS));
  assign key_wr    = top_en && (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = out_data_q;

  assign blk_in  = in_data ^ ((CBC_EN && cbc && mode) ? iv_q : '0);
  assign blk_res = {x_q[3], x_q[2], x_q[1], x_q[0]} ^ ((cbc_q && !mode_q) ? iv_q : '0);

  for (genvar i = 0; i < 4; i++) begin : g_chain_in
    assign w[i] = x_q[i];
  end

  // Round k of this pass uses key counter+k; decrypt walks the file backwards (31-idx == ~idx).
  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    logic [4:0] idx;
    assign idx = cnt_q[4:0] + 5'(k);
    sm4_round u_round (
      .x0 (w[k]),
      .x1 (w[k+1]),
      .x2 (w[k+2]),
      .x3 (w[k+3]),
      .rk (rk_mem[mode_q ? idx : ~idx]),
      .x4 (w[k+4])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept)    state_d = StBusy;
      StBusy:  if (last)      state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  always_ff @(posedge top_clk) begin
    if (top_rst) begin
      state_q    <= StIdle;
      rk_bits_q  <= '0;
      iv_q       <= '0;
      out_data_q <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      cbc_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (key_wr) rk_bits_q[top_keyaddr] <= 1'b1;
      if (state_q == StIdle && iv_load && CBC_EN) iv_q <= iv_in;
      if (accept) begin
        mode_q <= mode;
        cbc_q  <= CBC_EN && cbc;
        cnt_q  <= '0;
      end
      if (state_q == StBusy && !last) cnt_q <= cnt_q + 6'(UNROLL);
      if (state_q == StBusy && last) out_data_q <= blk_res;
      // Chain on the handshake so a stalled result never disturbs the IV early.
      if (state_q == StDone && out_ready && cbc_q) iv_q <= mode_q ? out_data_q : ct_q;
    end
  end

  // Key contents and datapath words carry no reset.
  always_ff @(posedge top_clk) begin
    if (key_wr) rk_mem[top_keyaddr] <= top_rk;
    if (accept) begin
      ct_q <= in_data;
      for (int i = 0; i < 4; i++) x_q[i] <= blk_in[127-32*i -: 32];
    end else if (state_q == StBusy && !last) begin
      for (int i = 0; i < 4; i++) x_q[i] <= w[UNROLL+i];
    end
  end

endmodule

// File: tb/tb_sm4_iter_core.sv
// Self-checking bench: three core builds (UNROLL 4 with CBC, 1, 32) against a block-level model.
module tb_sm4_iter_core;
  import sm4_pkg::*;

  localparam int ND = 3;
  localparam int unsigned UN [ND] = '{4, 1, 32};
  localparam bit CBCE [ND] = '{1'b1, 1'b0, 1'b0};
  localparam int LAT [ND] = '{9, 33, 2};
  localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_CT  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] IV0     = 128'h000102030405060708090a0b0c0d0e0f;

  logic top_clk = 1'b0;
  always #5 top_clk = ~top_clk;

  logic rst [ND], en [ND], rk_rdy [ND], mode [ND], cbc [ND], iv_load [ND];
  logic in_valid [ND], in_ready [ND], out_valid [ND], out_ready [ND];
  logic [4:0] kaddr [ND];
  logic [31:0] rkw [ND];
  logic [127:0] iv_in [ND], in_data [ND], out_data [ND];

  sm4_iter_core #(.UNROLL(4), .CBC_EN(1'b1)) u_d0 (
    .top_clk(top_clk), .top_rst(rst[0]), .top_en(en[0]), .top_keyaddr(kaddr[0]), .top_rk(rkw[0]),
    .rk_ready(rk_rdy[0]), .mode(mode[0]), .cbc(cbc[0]), .iv_load(iv_load[0]), .iv_in(iv_in[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]));
  sm4_iter_core #(.UNROLL(1), .CBC_EN(1'b0)) u_d1 (
    .top_clk(top_clk), .top_rst(rst[1]), .top_en(en[1]), .top_keyaddr(kaddr[1]), .top_rk(rkw[1]),
    .rk_ready(rk_rdy[1]), .mode(mode[1]), .cbc(cbc[1]), .iv_load(iv_load[1]), .iv_in(iv_in[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]));
  sm4_iter_core #(.UNROLL(32), .CBC_EN(1'b0)) u_d2 (
    .top_clk(top_clk), .top_rst(rst[2]), .top_en(en[2]), .top_keyaddr(kaddr[2]), .top_rk(rkw[2]),
    .rk_ready(rk_rdy[2]), .mode(mode[2]), .cbc(cbc[2]), .iv_load(iv_load[2]), .iv_in(iv_in[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] kref [32];

  // Model state: phase 0 idle, 1 busy (m_cnt edges left), 2 result pending.
  logic         m_known [ND] = '{1'b0, 1'b0, 1'b0};
  int           m_ph [ND];
  int           m_cnt [ND];
  logic [31:0]  m_bits [ND];
  logic [31:0]  m_keys [ND][32];
  logic         m_mode [ND], m_cbc [ND];
  logic [127:0] m_iv [ND], m_ct [ND], m_out [ND];

  task automatic chk(input string nm, input int d, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s dut%0d: got %h, want %h", nm, d, act, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic void gen_keys(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] b;
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ FK[i];
    for (int i = 0; i < 32; i++) begin
      b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ CK[i]);
      k[i+4] = k[i] ^ b ^ rol(b, 13) ^ rol(b, 23);
      kref[i] = k[i+4];
    end
  endfunction

  function automatic logic [127:0] sm4_ref(input int d, input logic [127:0] blk, input logic enc);
    logic [31:0] x [36];
    logic [31:0] b;
    for (int i = 0; i < 4; i++) x[i] = blk[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      b = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ m_keys[d][enc ? i : 31 - i]);
      x[i+4] = x[i] ^ b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  always @(posedge top_clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst[d]) begin
        m_known[d] <= 1'b1;
        m_ph[d]    <= 0;
        m_bits[d]  <= '0;
        m_iv[d]    <= '0;
      end else begin
        case (m_ph[d])
          0: begin
            if (in_valid[d] && m_bits[d] == '1 && !iv_load[d]) begin
              m_mode[d] <= mode[d];
              m_cbc[d]  <= CBCE[d] && cbc[d];
              m_ct[d]   <= in_data[d];
              m_cnt[d]  <= 32 / UN[d] + 1;
              m_ph[d]   <= 1;
              if (CBCE[d] && cbc[d] && mode[d])
                m_out[d] <= sm4_ref(d, in_data[d] ^ m_iv[d], 1'b1);
              else if (CBCE[d] && cbc[d]) m_out[d] <= sm4_ref(d, in_data[d], 1'b0) ^ m_iv[d];
              else m_out[d] <= sm4_ref(d, in_data[d], mode[d]);
            end
            if (CBCE[d] && iv_load[d]) m_iv[d] <= iv_in[d];
            if (en[d]) begin
              m_keys[d][kaddr[d]] <= rkw[d];
              m_bits[d][kaddr[d]] <= 1'b1;
            end
          end
          1: begin
            m_cnt[d] <= m_cnt[d] - 1;
            if (m_cnt[d] == 1) m_ph[d] <= 2;
          end
          default: if (out_ready[d]) begin
            m_ph[d] <= 0;
            if (m_cbc[d]) m_iv[d] <= m_mode[d] ? m_out[d] : m_ct[d];
          end
        endcase
      end
    end
  end

  always @(negedge top_clk) begin
    #1;
    for (int d = 0; d < ND; d++) begin
      if (m_known[d]) begin
        chk("in_ready", d, 128'(in_ready[d]),
            128'(m_ph[d] == 0 && m_bits[d] == '1 && !iv_load[d]));
        chk("out_valid", d, 128'(out_valid[d]), 128'(m_ph[d] == 2));
        chk("rk_ready", d, 128'(rk_rdy[d]), 128'(m_bits[d] == '1));
        if (m_ph[d] == 2) chk("out_data", d, out_data[d], m_out[d]);
      end
    end
  end

  task automatic load_keys(input int d, input int upto);
    for (int i = 0; i < upto; i++) begin
      en[d] = 1'b1;
      kaddr[d] = 5'(i);
      rkw[d] = kref[i];
      @(negedge top_clk);
    end
    en[d] = 1'b0;
  endtask

  task automatic run_block(input int d, input logic [127:0] din, input logic md, input logic cb,
                           output logic [127:0] res, output int lat);
    int t;
    in_valid[d] = 1'b1;
    in_data[d] = din;
    mode[d] = md;
    cbc[d] = cb;
    #1;
    t = 0;
    while (!in_ready[d] && t < 100) begin
      @(negedge top_clk);
      #1;
      t++;
    end
    chk("accept_in_time", d, 128'(t < 100), 128'(1));
    @(negedge top_clk);
    in_valid[d] = 1'b0;
    lat = 0;
    #1;
    while (!out_valid[d] && lat < 100) begin
      @(negedge top_clk);
      #1;
      lat++;
    end
    res = out_data[d];
    @(negedge top_clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] r, p1, p2, c1, c2;
    int lat;
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1; en[d] = 1'b0; kaddr[d] = '0; rkw[d] = '0; mode[d] = 1'b1; cbc[d] = 1'b0;
      iv_load[d] = 1'b0; iv_in[d] = '0; in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b1;
    end
    gen_keys(STD_KEY);
    chk("ks_rk0", 0, 128'(kref[0]), 128'(32'hf12186f9));
    chk("ks_rk31", 0, 128'(kref[31]), 128'(32'h9124a012));
    repeat (2) @(negedge top_clk);
    for (int d = 0; d < ND; d++) rst[d] = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("rst_in_ready", d, 128'(in_ready[d]), 128'(0));
      chk("rst_out_valid", d, 128'(out_valid[d]), 128'(0));
      chk("rst_out_data", d, out_data[d], 128'(0));
      chk("rst_rk_ready", d, 128'(rk_rdy[d]), 128'(0));
    end
    @(negedge top_clk);

    // Key gating on the CBC build.
    load_keys(0, 31);
    in_valid[0] = 1'b1;
    in_data[0] = STD_KEY;
    #1;
    chk("gate31_rk_ready", 0, 128'(rk_rdy[0]), 128'(0));
    chk("gate31_in_ready", 0, 128'(in_ready[0]), 128'(0));
    @(negedge top_clk);
    in_valid[0] = 1'b0;
    en[0] = 1'b1; kaddr[0] = 5'd31; rkw[0] = kref[31];
    @(negedge top_clk);
    en[0] = 1'b0;
    #1;
    chk("gate32_in_ready", 0, 128'(in_ready[0]), 128'(1));
    chk("model_enc_vec", 0, sm4_ref(0, STD_KEY, 1'b1), STD_CT);
    chk("model_dec_vec", 0, sm4_ref(0, STD_CT, 1'b0), STD_KEY);
    @(negedge top_clk);

    for (int d = 0; d < ND; d++) begin
      if (d > 0) load_keys(d, 32);
      run_block(d, STD_KEY, 1'b1, 1'b0, r, lat);
      chk("std_enc", d, r, STD_CT);
      chk("std_enc_latency", d, 128'(lat), 128'(LAT[d]));
      run_block(d, STD_CT, 1'b0, 1'b0, r, lat);
      chk("std_dec", d, r, STD_KEY);
    end

    // Key writes while busy are discarded.
    in_valid[0] = 1'b1; in_data[0] = STD_KEY; mode[0] = 1'b1; cbc[0] = 1'b0;
    @(negedge top_clk);
    in_valid[0] = 1'b0;
    en[0] = 1'b1; kaddr[0] = 5'd5; rkw[0] = '0;
    repeat (3) @(negedge top_clk);
    en[0] = 1'b0;
    lat = 0;
    #1;
    while (!out_valid[0] && lat < 100) begin @(negedge top_clk); #1; lat++; end
    chk("busy_write_ignored", 0, out_data[0], STD_CT);
    @(negedge top_clk);

    // Backpressure.
    out_ready[0] = 1'b0;
    run_block(0, STD_CT, 1'b0, 1'b0, r, lat);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_valid", 0, 128'(out_valid[0]), 128'(1));
      chk("bp_data", 0, out_data[0], STD_KEY);
      chk("bp_in_ready", 0, 128'(in_ready[0]), 128'(0));
      @(negedge top_clk);
    end
    out_ready[0] = 1'b1;
    run_block(0, STD_KEY, 1'b1, 1'b0, r, lat);
    chk("bp_next_block", 0, r, STD_CT);
    chk("bp_next_latency", 0, 128'(lat), 128'(9));

    // CBC round trip.
    iv_in[0] = IV0;
    iv_load[0] = 1'b1;
    #1;
    chk("iv_load_blocks", 0, 128'(in_ready[0]), 128'(0));
    @(negedge top_clk);
    iv_load[0] = 1'b0;
    p1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    p2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_block(0, p1, 1'b1, 1'b1, c1, lat);
    chk("cbc_c1", 0, c1, sm4_ref(0, p1 ^ IV0, 1'b1));
    run_block(0, p2, 1'b1, 1'b1, c2, lat);
    chk("cbc_c2", 0, c2, sm4_ref(0, p2 ^ c1, 1'b1));
    iv_load[0] = 1'b1;
    @(negedge top_clk);
    iv_load[0] = 1'b0;
    run_block(0, c1, 1'b0, 1'b1, r, lat);
    chk("cbc_p1", 0, r, p1);
    run_block(0, c2, 1'b0, 1'b1, r, lat);
    chk("cbc_p2", 0, r, p2);
    run_block(0, p2 ^ c1, 1'b1, 1'b0, r, lat);
    chk("cbc_c2_as_ecb", 0, r, c2);

    // Randomized traffic on all three builds, checked cycle by cycle against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < ND; d++) begin
        in_valid[d] = ($urandom_range(0, 2) != 0);
        in_data[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
        mode[d] = 1'($urandom_range(0, 1));
        cbc[d] = 1'($urandom_range(0, 1));
        iv_load[d] = ($urandom_range(0, 9) == 0);
        iv_in[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
        out_ready[d] = ($urandom_range(0, 3) != 0);
        en[d] = !in_valid[d] && ($urandom_range(0, 7) == 0);
        kaddr[d] = 5'($urandom_range(0, 31));
        rkw[d] = $urandom();
      end
      @(negedge top_clk);
    end
    for (int d = 0; d < ND; d++) begin
      in_valid[d] = 1'b0; en[d] = 1'b0; iv_load[d] = 1'b0; out_ready[d] = 1'b1; cbc[d] = 1'b0;
    end
    repeat (40) @(negedge top_clk);

    // Reset in the third busy cycle aborts the block.
    in_valid[0] = 1'b1; in_data[0] = STD_KEY; mode[0] = 1'b1;
    #1;
    chk("pre_abort_ready", 0, 128'(in_ready[0]), 128'(1));
    @(negedge top_clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge top_clk);
    rst[0] = 1'b1;
    @(negedge top_clk);
    rst[0] = 1'b0;
    #1;
    chk("abort_in_ready", 0, 128'(in_ready[0]), 128'(0));
    chk("abort_rk_ready", 0, 128'(rk_rdy[0]), 128'(0));
    for (int i = 0; i < 12; i++) begin
      @(negedge top_clk);
      #1;
      chk("abort_no_output", 0, 128'(out_valid[0]), 128'(0));
    end
    @(negedge top_clk);
    load_keys(0, 32);
    run_block(0, STD_KEY, 1'b1, 1'b0, r, lat);
    chk("post_abort_enc", 0, r, STD_CT);
    chk("post_abort_latency", 0, 128'(lat), 128'(9));

    repeat (2) @(negedge top_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
